tiled_bg_scroll_mapper: RTL and testbench

// Parametrised background tile renderer. Successor to the single-image ROM mappers.

---
 rtl/tiled_bg_scroll_mapper_if.sv | 57 +++++
 rtl/tiled_bg_scroll_mapper.sv | 113 +++++++++++
 tb/tb_tiled_bg_scroll_mapper.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiled_bg_scroll_mapper_if.sv
// Video/ROM/palette bundle for tiled_bg_scroll_mapper.
// opaque exists only when TRANSPARENT_KEY_EN is defined.
interface tiled_bg_scroll_mapper_if #(
  parameter int TILE_W     = 64,
  parameter int TILE_H     = 64,
  parameter int SCALE_LOG2 = 2,
  parameter int IDX_W      = 4
);
  localparam int ADDR_W = $clog2(TILE_W * TILE_H);
  localparam int SX_W   = $clog2(TILE_W) + SCALE_LOG2;

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              scroll_en;
  logic              scroll_dir;
  logic [3:0]        scroll_step;
  logic [SX_W-1:0]   scroll_x;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
`ifdef TRANSPARENT_KEY_EN
  logic              opaque;
`endif

  modport slave (
    input  DrawX, DrawY, blank,
    input  scroll_en, scroll_dir, scroll_step,
    input  rom_q,
    input  pal_red, pal_green, pal_blue,
    output
`ifdef TRANSPARENT_KEY_EN
           opaque,
`endif
           scroll_x, rom_address, pal_index,
    output red, green, blue
  );

  modport master (
    output DrawX, DrawY, blank,
    output scroll_en, scroll_dir, scroll_step,
    output rom_q,
    output pal_red, pal_green, pal_blue,
    input
`ifdef TRANSPARENT_KEY_EN
           opaque,
`endif
           scroll_x, rom_address, pal_index,
    input  red, green, blue
  );
endinterface

// File: rtl/tiled_bg_scroll_mapper.sv
// Zoomed, horizontally scrolling tiled background; 3-edge pixel pipeline.
// Optional TRANSPARENT_KEY_EN: KEY_INDEX texels drive black and opaque=0.
module tiled_bg_scroll_mapper #(
  parameter int TILE_W     = 64,
  parameter int TILE_H     = 64,
  parameter int SCALE_LOG2 = 2,
  parameter int IDX_W      = 4,
`ifdef TRANSPARENT_KEY_EN
  parameter int KEY_INDEX  = 0,
`endif
  parameter int V_ACTIVE   = 480
) (
  input logic vga_clk,
  input logic reset,
  tiled_bg_scroll_mapper_if.slave bus
);
  localparam int COL_W  = $clog2(TILE_W);
  localparam int ROW_W  = $clog2(TILE_H);
  localparam int ADDR_W = $clog2(TILE_W * TILE_H);
  localparam int SX_W   = COL_W + SCALE_LOG2;

  logic [SX_W-1:0]   r_scroll_x;
  logic [SX_W-1:0]   w_step;
  logic [SX_W-1:0]   w_scroll_nxt;
  logic [SX_W-1:0]   w_sx;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_rom_address;
  logic              w_frame_start;
  logic              r_blank_d1;
  logic              r_blank_d2;
  logic              w_show;
  logic [3:0]        r_red;
  logic [3:0]        r_green;
  logic [3:0]        r_blue;

  assign w_frame_start = (bus.DrawX == 10'd0)
                      && (bus.DrawY == 10'(V_ACTIVE));

  // Period is a power of two, so modular wrap is plain overflow.
  assign w_step       = SX_W'(bus.scroll_step);
  assign w_scroll_nxt = bus.scroll_dir ? (r_scroll_x - w_step)
                                       : (r_scroll_x + w_step);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_scroll_x <= '0;
    end else if (w_frame_start && bus.scroll_en) begin
      r_scroll_x <= w_scroll_nxt;
    end
  end

  assign w_sx   = SX_W'(bus.DrawX) + r_scroll_x;
  assign w_col  = w_sx[SX_W-1 -: COL_W];
  assign w_row  = ROW_W'(bus.DrawY >> SCALE_LOG2);
  assign w_addr = ADDR_W'({w_row, w_col});

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rom_address <= '0;
      r_blank_d1    <= 1'b0;
      r_blank_d2    <= 1'b0;
    end else begin
      r_rom_address <= w_addr;
      r_blank_d1    <= bus.blank;
      r_blank_d2    <= r_blank_d1;
    end
  end

`ifdef TRANSPARENT_KEY_EN
  logic w_key;
  logic r_opaque;

  assign w_key  = (bus.rom_q == IDX_W'(KEY_INDEX));
  assign w_show = r_blank_d2 && !w_key;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_opaque <= 1'b0;
    end else begin
      r_opaque <= w_show;
    end
  end

  assign bus.opaque = r_opaque;
`else
  assign w_show = r_blank_d2;
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end else if (w_show) begin
      r_red   <= bus.pal_red;
      r_green <= bus.pal_green;
      r_blue  <= bus.pal_blue;
    end else begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
    end
  end

  assign bus.scroll_x    = r_scroll_x;
  assign bus.rom_address = r_rom_address;
  assign bus.pal_index   = bus.rom_q;
  assign bus.red         = r_red;
  assign bus.green       = r_green;
  assign bus.blue        = r_blue;
endmodule

// File: tb/tb_tiled_bg_scroll_mapper.sv
// Bench for tiled_bg_scroll_mapper: directed table, scroll/blank
// sequences and a randomized run against an arithmetic model.
module tb_tiled_bg_scroll_mapper;
  localparam int TILE_W = 64;
  localparam int TILE_H = 64;
  localparam int SL2    = 2;
  localparam int ZOOM   = 4;
  localparam int PERIOD = TILE_W * ZOOM;
  localparam int KEY    = 0;
  localparam int NRAND  = 2000;

  logic clk;
  logic rst;

  tiled_bg_scroll_mapper_if #(
    .TILE_W(TILE_W), .TILE_H(TILE_H),
    .SCALE_LOG2(SL2), .IDX_W(4)
  ) bus ();

  tiled_bg_scroll_mapper #(
    .TILE_W(TILE_W),
    .TILE_H(TILE_H),
    .SCALE_LOG2(SL2),
    .IDX_W(4),
`ifdef TRANSPARENT_KEY_EN
    .KEY_INDEX(KEY),
`endif
    .V_ACTIVE(480)
  ) dut (
    .vga_clk(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rom [0:4095];
  logic [3:0] pr [0:15];
  logic [3:0] pg [0:15];
  logic [3:0] pb [0:15];

  always @(posedge clk) bus.rom_q <= rom[bus.rom_address];

  always_comb begin
    bus.pal_red   = pr[bus.pal_index];
    bus.pal_green = pg[bus.pal_index];
    bus.pal_blue  = pb[bus.pal_index];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic int m_addr(input int x, input int y, input int s);
    int sx;
    sx = (x + s) % PERIOD;
    return ((y / ZOOM) % TILE_H) * TILE_W + sx / ZOOM;
  endfunction

  function automatic int m_show(input int a, input bit b);
    if (!b) return 0;
`ifdef TRANSPARENT_KEY_EN
    if (int'(rom[a]) == KEY) return 0;
`endif
    return 1;
  endfunction

  function automatic int m_rgb(input int a, input bit b);
    int i;
    i = int'(rom[a]);
    if (m_show(a, b) == 0) return 0;
    return int'(pr[i]) * 256 + int'(pg[i]) * 16 + int'(pb[i]);
  endfunction

  function automatic int m_scroll(input int s, input bit d, input int st);
    if (d) return (s - st + PERIOD) % PERIOD;
    return (s + st) % PERIOD;
  endfunction

  function automatic int dut_rgb;
    return int'({bus.red, bus.green, bus.blue});
  endfunction

  task automatic chk_pix(input string nm, input int a, input bit b);
    chk({nm, ".rgb"}, dut_rgb(), m_rgb(a, b));
`ifdef TRANSPARENT_KEY_EN
    chk({nm, ".opaque"}, int'(bus.opaque), m_show(a, b));
`endif
  endtask

  task automatic frame(input bit en, input bit d, input int st, input int exp);
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd480;
    bus.scroll_en   = en;
    bus.scroll_dir  = d;
    bus.scroll_step = 4'(st);
    tick();
    bus.DrawY     = 10'd0;
    bus.scroll_en = 1'b0;
    chk("scroll_frame", int'(bus.scroll_x), exp);
  endtask

  typedef struct {
    int x;
    int y;
    bit b;
    int addr;
  } vec_t;

  vec_t tv [8];

  int ex_addr [NRAND];
  int ex_sx   [NRAND];
  int ex_rgb  [NRAND];
  int ex_opq  [NRAND];

  initial begin
    tv[0] = '{5,   9,    1'b1, 129};
    tv[1] = '{0,   0,    1'b1, 0};
    tv[2] = '{3,   3,    1'b0, 0};
    tv[3] = '{4,   4,    1'b1, 65};
    tv[4] = '{255, 255,  1'b1, 4095};
    tv[5] = '{256, 0,    1'b1, 0};
    tv[6] = '{639, 479,  1'b1, 3551};
    tv[7] = '{700, 1023, 1'b0, 4079};

    for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) begin
      pr[i] = 4'($urandom_range(1, 15));
      pg[i] = 4'($urandom_range(1, 15));
      pb[i] = 4'($urandom_range(1, 15));
    end
    rom[129] = 4'd5;
    rom[65]  = 4'(KEY);

    // reset held across a frame_start with scroll enabled
    rst             = 1'b1;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd480;
    bus.blank       = 1'b1;
    bus.scroll_en   = 1'b1;
    bus.scroll_dir  = 1'b0;
    bus.scroll_step = 4'd5;
    tick();
    tick();
    chk("reset.scroll_x", int'(bus.scroll_x), 0);
    chk("reset.rom_address", int'(bus.rom_address), 0);
    chk("reset.rgb", dut_rgb(), 0);
`ifdef TRANSPARENT_KEY_EN
    chk("reset.opaque", int'(bus.opaque), 0);
`endif
    bus.scroll_en = 1'b0;
    bus.DrawY     = 10'd0;
    rst           = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      bus.DrawX = 10'(tv[i].x);
      bus.DrawY = 10'(tv[i].y);
      bus.blank = tv[i].b;
      tick();
      chk($sformatf("tv%0d.addr", i), int'(bus.rom_address), tv[i].addr);
      tick();
      tick();
      chk_pix($sformatf("tv%0d", i), tv[i].addr, tv[i].b);
    end

    // blank falls: two more active pixels, then black
    bus.DrawX = 10'd5;
    bus.DrawY = 10'd9;
    bus.blank = 1'b1;
    tick();
    tick();
    tick();
    bus.blank = 1'b0;
    tick();
    chk_pix("blank.e1", 129, 1'b1);
    tick();
    chk_pix("blank.e2", 129, 1'b1);
    tick();
    chk_pix("blank.e3", 129, 1'b0);

    // scroll_en outside frame_start is ignored
    bus.scroll_en   = 1'b1;
    bus.scroll_dir  = 1'b0;
    bus.scroll_step = 4'd7;
    bus.DrawX = 10'd100;
    bus.DrawY = 10'd100;
    tick();
    tick();
    tick();
    chk("midframe.scroll", int'(bus.scroll_x), 0);
    bus.DrawX = 10'd1;
    bus.DrawY = 10'd480;
    tick();
    chk("x1_y480.scroll", int'(bus.scroll_x), 0);
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd479;
    tick();
    chk("x0_y479.scroll", int'(bus.scroll_x), 0);
    bus.scroll_en = 1'b0;

    frame(1'b1, 1'b1, 2, 254);
    frame(1'b1, 1'b0, 3, 1);
    frame(1'b1, 1'b1, 3, 254);
    frame(1'b1, 1'b0, 0, 254);
    frame(1'b0, 1'b0, 5, 254);
    frame(1'b1, 1'b0, 10, 8);

    bus.DrawX = 10'd0;
    bus.DrawY = 10'd260;
    bus.blank = 1'b1;
    tick();
    chk("row_wrap.addr", int'(bus.rom_address), 66);

    // randomized streaming against the model, scroll currently 8
    begin
      int s_m;
      int x;
      int y;
      bit b;
      bit fs;
      s_m = 8;
      for (int j = 0; j < NRAND + 3; j++) begin
        if (j >= 1 && j <= NRAND) begin
          chk("rnd.addr", int'(bus.rom_address), ex_addr[j-1]);
          chk("rnd.scroll", int'(bus.scroll_x), ex_sx[j-1]);
        end
        if (j >= 3) begin
          chk("rnd.rgb", dut_rgb(), ex_rgb[j-3]);
`ifdef TRANSPARENT_KEY_EN
          chk("rnd.opaque", int'(bus.opaque), ex_opq[j-3]);
`endif
        end
        if (j < NRAND) begin
          fs = ($urandom_range(0, 5) == 0);
          x  = fs ? 0 : int'($urandom_range(0, 1023));
          y  = fs ? 480 : int'($urandom_range(0, 1023));
          b  = 1'($urandom_range(0, 1));
          bus.DrawX       = 10'(x);
          bus.DrawY       = 10'(y);
          bus.blank       = b;
          bus.scroll_en   = 1'($urandom_range(0, 1));
          bus.scroll_dir  = 1'($urandom_range(0, 1));
          bus.scroll_step = 4'($urandom_range(0, 15));
          ex_addr[j] = m_addr(x, y, s_m);
          ex_rgb[j]  = m_rgb(ex_addr[j], b);
          ex_opq[j]  = m_show(ex_addr[j], b);
          if ((x == 0) && (y == 480) && bus.scroll_en)
            s_m = m_scroll(s_m, bus.scroll_dir, int'(bus.scroll_step));
          ex_sx[j] = s_m;
        end else begin
          bus.scroll_en = 1'b0;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
